// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings and output-set helpers for the pipeline front-end controllers.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2,
        HALTED   = 2'd3
    } state_t;

    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         FLUSH_CNT_WIDTH = 4;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic pc_sel_branch;
        logic if_id_flush;
        logic id_ex_bubble;
    } ctrl_t;

    function automatic ctrl_t ctrl_advance();
        ctrl_t c;
        c             = '0;
        c.pc_write    = 1'b1;
        c.if_id_write = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t ctrl_freeze();
        ctrl_t c;
        c = '0;
        return c;
    endfunction

    // Held while reset is asserted so no stale instruction escapes into ID/EX.
    function automatic ctrl_t ctrl_reset();
        ctrl_t c;
        c              = '0;
        c.if_id_flush  = 1'b1;
        c.id_ex_bubble = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/fetch_hazard_controller_if.sv
// Hazard inputs from the pipeline and sequencing controls back to the front end.
interface fetch_hazard_controller_if #(
    parameter int STALL_CNT_WIDTH = 16
);
    logic                       idExMemRead;
    logic [4:0]                 idExRt;
    logic [4:0]                 ifIdRs;
    logic [4:0]                 ifIdRt;
    logic                       ifIdUsesRt;
    logic                       branchTaken;
    logic                       memBusy;
    logic                       haltReq;
    logic                       pcWrite;
    logic                       ifIdWrite;
    logic                       pcSelBranch;
    logic                       ifIdFlush;
    logic                       idExBubble;
    logic                       halted;
    logic [STALL_CNT_WIDTH-1:0] stallCount;

    modport master (
        output idExMemRead, idExRt, ifIdRs, ifIdRt, ifIdUsesRt,
               branchTaken, memBusy, haltReq,
        input  pcWrite, ifIdWrite, pcSelBranch, ifIdFlush, idExBubble,
               halted, stallCount
    );

    modport slave (
        input  idExMemRead, idExRt, ifIdRs, ifIdRt, ifIdUsesRt,
               branchTaken, memBusy, haltReq,
        output pcWrite, ifIdWrite, pcSelBranch, ifIdFlush, idExBubble,
               halted, stallCount
    );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use comparator; also reused by the forwarding unit.
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic       mem_read,
    input  logic [4:0] dest,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       uses_rt,
    output logic       hazard
);
    logic [4:0] rs_eq_bits;
    logic [4:0] rt_eq_bits;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_cmp
            assign rs_eq_bits[gi] = ~(dest[gi] ^ rs[gi]);
            assign rt_eq_bits[gi] = ~(dest[gi] ^ rt[gi]);
        end
    endgenerate

    // Writes to r0 are discarded, so a load into r0 never creates a dependency.
    assign hazard = mem_read && (dest != REG_ZERO) &&
                    ((&rs_eq_bits) || (uses_rt && (&rt_eq_bits)));

endmodule

// File: rtl/fetch_hazard_controller.sv
// Front-end sequencing: load-use stalls, branch flushes, memory freeze and sticky halt.
module fetch_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES    = 1,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    fetch_hazard_controller_if.slave bus
);
    localparam logic [FLUSH_CNT_WIDTH-1:0] FLUSH_RELOAD = FLUSH_CNT_WIDTH'(FLUSH_CYCLES - 1);
    localparam bit                         MULTI_FLUSH  = (FLUSH_CYCLES > 1);
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE    = {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                       state_reg, state_next;
    logic [FLUSH_CNT_WIDTH-1:0]   flush_left_reg, flush_left_next;
    logic [STALL_CNT_WIDTH-1:0]   stall_count_reg;
    ctrl_t                        ctrl;
    logic                         halted_flag;
    logic                         hazard;

    load_use_detect u_load_use_detect (
        .mem_read (bus.idExMemRead),
        .dest     (bus.idExRt),
        .rs       (bus.ifIdRs),
        .rt       (bus.ifIdRt),
        .uses_rt  (bus.ifIdUsesRt),
        .hazard   (hazard)
    );

    always_comb begin
        state_next      = state_reg;
        flush_left_next = flush_left_reg;
        ctrl            = ctrl_advance();
        halted_flag     = 1'b0;
        if (reset) begin
            ctrl            = ctrl_reset();
            state_next      = RUN;
            flush_left_next = '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (bus.haltReq) begin
                        ctrl       = ctrl_freeze();
                        state_next = HALTED;
                    end else if (bus.memBusy) begin
                        ctrl       = ctrl_freeze();
                        state_next = MEM_WAIT;
                    end else if (bus.branchTaken) begin
                        ctrl.pc_sel_branch = 1'b1;
                        ctrl.if_id_flush   = 1'b1;
                        ctrl.id_ex_bubble  = 1'b1;
                        if (MULTI_FLUSH) begin
                            state_next      = FLUSH;
                            flush_left_next = FLUSH_RELOAD;
                        end
                    end else if (hazard) begin
                        ctrl.pc_write     = 1'b0;
                        ctrl.if_id_write  = 1'b0;
                        ctrl.id_ex_bubble = 1'b1;
                    end
                end
                FLUSH: begin
                    // A busy memory pauses the flush without consuming a squash slot.
                    if (bus.haltReq) begin
                        ctrl       = ctrl_freeze();
                        state_next = HALTED;
                    end else if (bus.memBusy) begin
                        ctrl = ctrl_freeze();
                    end else begin
                        ctrl.if_id_flush  = 1'b1;
                        ctrl.id_ex_bubble = 1'b1;
                        flush_left_next   = flush_left_reg - 1'b1;
                        if (flush_left_reg <= 4'd1) begin
                            state_next = RUN;
                        end
                    end
                end
                MEM_WAIT: begin
                    ctrl = ctrl_freeze();
                    if (!bus.memBusy) begin
                        state_next = bus.haltReq ? HALTED : RUN;
                    end
                end
                HALTED: begin
                    ctrl        = ctrl_freeze();
                    halted_flag = 1'b1;
                end
                default: begin
                    ctrl       = ctrl_freeze();
                    state_next = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= RUN;
            flush_left_reg  <= '0;
            stall_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            flush_left_reg <= flush_left_next;
            if (!ctrl.pc_write && (state_reg != HALTED) && (stall_count_reg != '1)) begin
                stall_count_reg <= stall_count_reg + STALL_ONE;
            end
        end
    end

    assign bus.pcWrite     = ctrl.pc_write;
    assign bus.ifIdWrite   = ctrl.if_id_write;
    assign bus.pcSelBranch = ctrl.pc_sel_branch;
    assign bus.ifIdFlush   = ctrl.if_id_flush;
    assign bus.idExBubble  = ctrl.id_ex_bubble;
    assign bus.halted      = halted_flag;
    assign bus.stallCount  = stall_count_reg;

endmodule

// File: doc/fetch_hazard_controller.md
# fetch_hazard_controller

Sequencing controller for the instruction-fetch stage and the IF/ID and ID/EX pipeline registers. It detects load-use hazards, flushes on taken branches, freezes the front end while data memory is busy, and implements a sticky halt. It drives `pcWrite`, `ifIdWrite` and the companion flush/bubble/select controls, and keeps a saturating stall-cycle counter.

## Interface
- `FLUSH_CYCLES`, default 1: cycles IF/ID and ID/EX are squashed per taken branch; legal range 1..15.
- `STALL_CNT_WIDTH`, default 16: width of `stallCount`.

Ports:
- `clk`  in  1  system clock; state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `idExMemRead`  in  1  instruction in ID/EX is a load.
- `idExRt`  in  5  destination register of the ID/EX load.
- `ifIdRs`  in  5  rs field of the IF/ID instruction.
- `ifIdRt`  in  5  rt field of the IF/ID instruction.
- `ifIdUsesRt`  in  1  IF/ID instruction reads rt.
- `branchTaken`  in  1  EX resolved a taken branch this cycle.
- `memBusy`  in  1  data memory not ready.
- `haltReq`  in  1  halt instruction reached EX.
- `pcWrite`  out  1  PC may advance.
- `ifIdWrite`  out  1  IF/ID may load.
- `pcSelBranch`  out  1  PC loads branch target instead of PC+4.
- `ifIdFlush`  out  1  IF/ID loads a NOP.
- `idExBubble`  out  1  ID/EX loads a NOP.
- `halted`  out  1  controller is in HALTED.
- `stallCount`  out  `STALL_CNT_WIDTH`  saturating count of stalled cycles.

## Operation
- States: RUN, FLUSH, MEM_WAIT, HALTED. A down-counter `flushLeft` has width 4.
- Outputs are decoded combinationally from state and current inputs. The negedge-clocked fetch stage samples them mid-cycle.
- Default output set "advance": pcWrite=1, ifIdWrite=1, all others 0.
- Output set "freeze": pcWrite=0, ifIdWrite=0, ifIdFlush=0, idExBubble=0, pcSelBranch=0.
- Load-use hazard is true when idExMemRead=1, idExRt≠0, and either idExRt==ifIdRs or (ifIdUsesRt=1 and idExRt==ifIdRt).
- RUN evaluates conditions in priority order:
  1. haltReq: freeze, then next state HALTED.
  2. memBusy: freeze, then next state MEM_WAIT.
  3. branchTaken: pcWrite=1, pcSelBranch=1, ifIdFlush=1, idExBubble=1. If FLUSH_CYCLES>1, go to FLUSH with flushLeft=FLUSH_CYCLES−1.
  4. Load-use hazard: pcWrite=0, ifIdWrite=0, idExBubble=1; stay in RUN.
  5. Otherwise: advance.
- FLUSH:
  - haltReq: freeze, then HALTED.
  - memBusy: freeze, and flushLeft holds.
  - Otherwise: pcWrite=1, ifIdWrite=1, ifIdFlush=1, idExBubble=1. Decrement flushLeft; return to RUN when it reaches 0.
  - branchTaken and load-use are ignored in FLUSH.
- MEM_WAIT:
  - Always freeze.
  - On a posedge with memBusy=0, go to HALTED if haltReq=1, else RUN.
  - Net effect: freeze lasts (busy cycles + 1).
- HALTED: freeze, halted=1. Only reset exits this state.
- stallCount increments by 1 on each posedge where pcWrite=0 and state≠HALTED. It saturates at all-ones and never wraps.

## Timing
- Reset (sampled at posedge) sets state=RUN, flushLeft=0, stallCount=0.
- While reset=1, outputs are forced to: pcWrite=0, ifIdWrite=0, ifIdFlush=1, idExBubble=1, pcSelBranch=0, halted=0.
- Reset mid-FLUSH, MEM_WAIT or HALTED abandons that state immediately. The first cycle after reset deasserts is RUN.
- A load-use stall lasts exactly one cycle with no state change. The next cycle the bubble is in ID/EX, so idExMemRead=0 and the hazard clears naturally.
- A taken branch costs FLUSH_CYCLES squashed cycles in total, including the cycle branchTaken is seen.
- Simultaneous events resolve strictly by the priority list above; for example, memBusy and branchTaken together freeze and the branch is re-presented by EX.
- Input-to-output latency is zero (combinational). State effects take hold from the next posedge.

## Structure
- A shared package `pipeline_ctrl_pkg` holds:
  - the state encoding (2-bit localparams RUN=0, FLUSH=1, MEM_WAIT=2, HALTED=3);
  - the register-zero constant;
  - the output-set macros/functions for advance and freeze.
- One sub-module, `load_use_detect`: purely combinational hazard comparator, reused later by the forwarding unit.
- Expected size: about 150–250 lines in total.

## Test plan
- Reset held 2 cycles while hazard inputs are active: outputs equal the reset set; after release, pcWrite=1, ifIdWrite=1, stallCount=0.
- idExMemRead=1, idExRt=5, ifIdRs=5: exactly one cycle with pcWrite=0 and idExBubble=1, and stallCount=1. Repeat with idExRt=0: no stall.
- branchTaken pulse with FLUSH_CYCLES=3: ifIdFlush=1 for 3 consecutive cycles, pcSelBranch=1 only in the first; back in RUN afterwards.
- memBusy high 3 cycles: pcWrite=0 for 4 cycles, stallCount=4. Same pulse during a FLUSH: flushLeft holds, and the flush completes after memBusy drops.
- haltReq together with branchTaken: HALTED on the next cycle, halted=1, stallCount frozen, writes stay 0 until reset.
- STALL_CNT_WIDTH=4 with a memBusy pulse of 20 cycles: stallCount saturates at 15 and does not wrap.
